// File: rtl/cmdin_acc_arbiter.sv
// cmdin_acc_arbiter
//   Packet-atomic round-robin arbiter merging NUM_SRCS AXI-Stream command
//   sources (host cmdin queue, accelerator spawn-out queue) into the single
//   cmdin stream of the accelerator interconnect. A granted source owns the
//   output until its tlast beat transfers. Each packet costs one idle cycle
//   for arbitration.
//
//   A word parser follows the command layout of the granted stream:
//     header : code at data[CMD_TYPE_H:CMD_TYPE_L] (= [7:0]),
//              nArgs at data[NUM_ARGS_OFFSET +: 8] (= [15:8])
//     codes  : SETUP_HW_INST = 8'h01, EXEC_PERI_TASK = 8'h03
//              (EXEC_TASK = 8'h02 and all others take the generic path)
//     flag   : flag bits in the low word, argument index in data[63:32]
//
//   Optional feature, macro CMDIN_COPY_OPT_EN: a per-(tdest, argIdx) table of
//   the last argument seen lets the block clear the copy-in bit (flag bit 4)
//   when an accelerator already holds the same argument. FLAG beats are
//   absorbed and re-emitted just ahead of their ARG beat. Without the macro
//   every beat passes through unmodified. tdest is assumed < NUM_ACCS and
//   MAX_ARGS >= 2.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_ready per-source tvalid/tready
//   s_data          per-source tdata, source i at [64*i +: 64]
//   s_dest          per-source tdest, source i at [ACC_BITS*i +: ACC_BITS]
//   s_last          per-source tlast
//   m_valid/m_ready cmdin tvalid/tready
//   m_data/m_dest/m_last  cmdin tdata/tdest/tlast
//   grant           source currently owning the output
//   busy            high while a packet is in flight
module cmdin_acc_arbiter #(
  parameter int NUM_SRCS = 2,
  parameter int NUM_ACCS = 16,
  parameter int ACC_BITS = 4,
  parameter int MAX_ARGS = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRCS-1:0]          s_valid,
  output logic [NUM_SRCS-1:0]          s_ready,
  input  logic [NUM_SRCS*64-1:0]       s_data,
  input  logic [NUM_SRCS*ACC_BITS-1:0] s_dest,
  input  logic [NUM_SRCS-1:0]          s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [63:0]                  m_data,
  output logic [ACC_BITS-1:0]          m_dest,
  output logic                         m_last,
  output logic [$clog2(NUM_SRCS)-1:0]  grant,
  output logic                         busy
);

  localparam int GW              = $clog2(NUM_SRCS);
  localparam int CMD_TYPE_L      = 0;
  localparam int CMD_TYPE_H      = 7;
  localparam int NUM_ARGS_OFFSET = 8;
  localparam logic [7:0] SETUP_HW_INST_CODE  = 8'h01;
  localparam logic [7:0] EXEC_PERI_TASK_CODE = 8'h03;

  typedef enum logic {IDLE, PASS} arb_state_t;
  typedef enum logic [2:0] {P_HDR, P_TID, P_PTID, P_PERI, P_FLAG, P_ARG} parse_state_t;

  arb_state_t   arb_state;
  parse_state_t pstate;
  logic [GW-1:0]       rr_ptr;
  logic [7:0]          code;
  logic [7:0]          nargs;
  logic [7:0]          arg_idx;
  logic                g_valid;
  logic                g_last;
  logic [63:0]         g_data;
  logic [ACC_BITS-1:0] g_dest;
  logic                take;

  // First requester at or after ptr, scanning cyclically.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_SRCS-1:0] req,
                                            input logic [GW-1:0] ptr);
    logic [GW-1:0] sel;
    logic          found;
    int            idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      idx = (int'(ptr) + k) % NUM_SRCS;
      if (!found && req[idx]) begin
        sel   = GW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign g_valid = s_valid[grant];
  assign g_last  = s_last[grant];
  assign g_data  = s_data[64*grant +: 64];
  assign g_dest  = s_dest[ACC_BITS*grant +: ACC_BITS];

  // A beat is consumed from the granted source (passed or absorbed).
  assign take = g_valid & s_ready[grant];

`ifdef CMDIN_COPY_OPT_EN
  localparam int IDX_W = $clog2(MAX_ARGS);

  logic              tbl_vld [NUM_ACCS][MAX_ARGS];
  logic [63:0]       tbl_arg [NUM_ACCS][MAX_ARGS];
  logic [63:0]       flag_q;
  logic              flag_held;
  logic [IDX_W-1:0]  tidx;
  logic              idx_ok;
  logic              absorb;
  logic              emit;
  logic              hit;
  logic              tbl_wr;
  logic [63:0]       flag_out;

  assign tidx   = arg_idx[IDX_W-1:0];
  assign idx_ok = arg_idx < 8'(MAX_ARGS);
  // A FLAG beat carrying tlast cannot be held back without losing the
  // packet end, so it is passed through untouched.
  assign absorb = (arb_state == PASS) && (pstate == P_FLAG) && !g_last;
  assign emit   = (arb_state == PASS) && (pstate == P_ARG) && flag_held;
  assign hit    = flag_q[4] && idx_ok && tbl_vld[g_dest][tidx] &&
                  (tbl_arg[g_dest][tidx] == g_data);
  assign flag_out = {flag_q[63:5], flag_q[4] & ~hit, flag_q[3:0]};
  assign tbl_wr = take && (pstate == P_ARG) && !flag_held && idx_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_held <= 1'b0;
    end else if (absorb && take) begin
      flag_held <= 1'b1;
    end else if (emit && g_valid && m_ready) begin
      flag_held <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (absorb && take) flag_q <= g_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NUM_ACCS; a++)
        for (int b = 0; b < MAX_ARGS; b++)
          tbl_vld[a][b] <= 1'b0;
    end else if (tbl_wr) begin
      tbl_vld[g_dest][tidx] <= flag_q[4];
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_wr) tbl_arg[g_dest][tidx] <= g_data;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAX_ARGS, NUM_ACCS};
`endif

  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_dest  = '0;
    m_last  = 1'b0;
    s_ready = '0;
    if (arb_state == PASS) begin
`ifdef CMDIN_COPY_OPT_EN
      if (absorb) begin
        s_ready[grant] = 1'b1;
      end else if (emit) begin
        m_valid = g_valid;
        m_data  = flag_out;
        m_dest  = g_dest;
      end else begin
        m_valid        = g_valid;
        m_data         = g_data;
        m_dest         = g_dest;
        m_last         = g_last;
        s_ready[grant] = m_ready;
      end
`else
      m_valid        = g_valid;
      m_data         = g_data;
      m_dest         = g_dest;
      m_last         = g_last;
      s_ready[grant] = m_ready;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_state <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      busy      <= 1'b0;
    end else begin
      case (arb_state)
        IDLE: begin
          if (|s_valid) begin
            grant     <= rr_pick(s_valid, rr_ptr);
            busy      <= 1'b1;
            arb_state <= PASS;
          end
        end
        PASS: begin
          if (take && g_last) begin
            rr_ptr    <= (grant == GW'(NUM_SRCS - 1)) ? '0 : grant + 1'b1;
            busy      <= 1'b0;
            arb_state <= IDLE;
          end
        end
        default: arb_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate <= P_HDR;
    end else if (take) begin
      if (g_last) begin
        pstate <= P_HDR;
      end else begin
        case (pstate)
          P_HDR:  pstate <= P_TID;
          P_TID:  pstate <= (code == SETUP_HW_INST_CODE) ? P_HDR : P_PTID;
          P_PTID: begin
            if (code == EXEC_PERI_TASK_CODE) pstate <= P_PERI;
            else if (nargs != 8'd0)          pstate <= P_FLAG;
            else                             pstate <= P_HDR;
          end
          P_PERI: pstate <= (nargs != 8'd0) ? P_FLAG : P_HDR;
          P_FLAG: pstate <= P_ARG;
          P_ARG:  pstate <= (arg_idx + 8'd1 == nargs) ? P_HDR : P_FLAG;
          default: pstate <= P_HDR;
        endcase
      end
    end
  end

  // Header fields and argument counter are only meaningful once the parser
  // has seen a header beat, so they carry no reset.
  always_ff @(posedge clk) begin
    if (take) begin
      if (pstate == P_HDR) begin
        code    <= g_data[CMD_TYPE_H:CMD_TYPE_L];
        nargs   <= g_data[NUM_ARGS_OFFSET +: 8];
        arg_idx <= 8'd0;
      end else if (pstate == P_ARG) begin
        arg_idx <= arg_idx + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmdin_acc_arbiter.sv
// Directed self-checking bench for cmdin_acc_arbiter (NUM_SRCS=2, ACC_BITS=4).
// Inputs are driven on the falling edge; outputs and handshakes are sampled
// 1 ns later, well before the next rising edge.
module tb_cmdin_acc_arbiter;

  localparam int AB = 4;
`ifdef CMDIN_COPY_OPT_EN
  localparam bit OPT = 1'b1;
`else
  localparam bit OPT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    s_valid, s_ready, s_last;
  logic [127:0]  s_data;
  logic [2*AB-1:0] s_dest;
  logic          m_valid, m_ready, m_last;
  logic [63:0]   m_data;
  logic [AB-1:0] m_dest;
  logic [0:0]    grant;
  logic          busy;

  always #5 clk = ~clk;

  cmdin_acc_arbiter #(.NUM_SRCS(2), .NUM_ACCS(16), .ACC_BITS(AB), .MAX_ARGS(15)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_dest(s_dest), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dest(m_dest), .m_last(m_last),
    .grant(grant), .busy(busy)
  );

  typedef struct packed {
    logic [63:0]   data;
    logic [AB-1:0] dest;
    logic          last;
  } beat_t;

  typedef struct {
    beat_t b;
    int    g;
    int    cyc;
    logic  bsy;
  } obs_t;

  beat_t q0[$];
  beat_t q1[$];
  obs_t  olog[$];
  beat_t exp_b[$];
  int    exp_g[$];
  int    exp_c[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  bit    toggle_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [63:0] d, input logic [AB-1:0] de, input logic l);
    beat_t b;
    b.data = d; b.dest = de; b.last = l;
    if (s == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  task automatic expb(input logic [63:0] d, input logic [AB-1:0] de, input logic l,
                      input int g, input int c);
    beat_t b;
    b.data = d; b.dest = de; b.last = l;
    exp_b.push_back(b);
    exp_g.push_back(g);
    exp_c.push_back(c);
  endtask

  task automatic drive();
    s_valid = '0; s_data = '0; s_dest = '0; s_last = '0;
    if (q0.size() > 0) begin
      s_valid[0] = 1'b1; s_data[63:0] = q0[0].data;
      s_dest[AB-1:0] = q0[0].dest; s_last[0] = q0[0].last;
    end
    if (q1.size() > 0) begin
      s_valid[1] = 1'b1; s_data[127:64] = q1[0].data;
      s_dest[2*AB-1:AB] = q1[0].dest; s_last[1] = q1[0].last;
    end
    m_ready = toggle_rdy ? (cyc % 2 == 1) : 1'b1;
  endtask

  // One clock: drive at negedge, sample handshakes, advance to next negedge.
  task automatic tick();
    obs_t o;
    drive();
    #1;
    if (m_valid && m_ready) begin
      o.b.data = m_data; o.b.dest = m_dest; o.b.last = m_last;
      o.g = int'(grant); o.cyc = cyc; o.bsy = busy;
      olog.push_back(o);
    end
    if (s_valid[0] && s_ready[0]) q0.delete(0);
    if (s_valid[1] && s_ready[1]) q1.delete(0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int budget);
    int  n;
    logic done;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    done = (q0.size() == 0 && q1.size() == 0 && !busy);
    chk({tag, ".completed"}, 64'(done), 64'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, ".beats"}, 64'(olog.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < olog.size(); i++) begin
      chk($sformatf("%s[%0d].data", tag, i), olog[i].b.data, exp_b[i].data);
      chk($sformatf("%s[%0d].dest", tag, i), 64'(olog[i].b.dest), 64'(exp_b[i].dest));
      chk($sformatf("%s[%0d].last", tag, i), 64'(olog[i].b.last), 64'(exp_b[i].last));
      chk($sformatf("%s[%0d].grant", tag, i), 64'(olog[i].g), 64'(exp_g[i]));
      chk($sformatf("%s[%0d].busy", tag, i), 64'(olog[i].bsy), 64'd1);
      if (exp_c[i] >= 0)
        chk($sformatf("%s[%0d].cycle", tag, i), 64'(olog[i].cyc), 64'(exp_c[i]));
    end
    olog.delete(); exp_b.delete(); exp_g.delete(); exp_c.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, ".m_last"},  64'(m_last),  64'd0);
    chk({tag, ".m_data"},  m_data,       64'd0);
    chk({tag, ".m_dest"},  64'(m_dest),  64'd0);
    chk({tag, ".s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, ".grant"},   64'(grant),   64'd0);
    chk({tag, ".busy"},    64'(busy),    64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete();
    toggle_rdy = 1'b0;
    drive();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    olog.delete();
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] arg;
    rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    cyc = 0;

    // Single source, EXEC_TASK nArgs=1, 4 beats, dest 5.
    push(0, 64'hA000_0000_0000_0102, 4'd5, 1'b0);
    push(0, 64'hA000_0000_0000_0011, 4'd5, 1'b0);
    push(0, 64'hA000_0000_0000_0022, 4'd5, 1'b0);
    push(0, 64'hA000_0000_0000_0010, 4'd5, 1'b1);
    expb(64'hA000_0000_0000_0102, 4'd5, 1'b0, 0, 1);
    expb(64'hA000_0000_0000_0011, 4'd5, 1'b0, 0, 2);
    expb(64'hA000_0000_0000_0022, 4'd5, 1'b0, 0, 3);
    expb(64'hA000_0000_0000_0010, 4'd5, 1'b1, 0, 4);
    run("single", 40);
    check_log("single");
    chk("single.busy_end", 64'(busy), 64'd0);

    // Both sources continuously valid, two 3-beat packets each.
    do_reset();
    for (int pk = 0; pk < 2; pk++)
      for (int s = 0; s < 2; s++)
        for (int j = 0; j < 3; j++) begin
          d = {8'h50 + 8'(s), 8'(pk), 8'(j), 24'h0, (j == 0) ? 16'h0001 : 16'h00AA};
          push(s, d, AB'(s + 1), j == 2);
          expb(d, AB'(s + 1), j == 2, s, (pk * 2 + s) * 4 + 1 + j);
        end
    run("rr", 80);
    check_log("rr");

    // Source 1 owns the output while m_ready toggles; source 0 waits.
    do_reset();
    toggle_rdy = 1'b1;
    push(1, 64'hB100_0000_0000_0001, 4'd9, 1'b0);
    push(1, 64'hB100_0000_0000_00B1, 4'd9, 1'b0);
    push(1, 64'hB100_0000_0000_00B2, 4'd9, 1'b1);
    tick();
    push(0, 64'hC000_0000_0000_0001, 4'd4, 1'b0);
    push(0, 64'hC000_0000_0000_00C1, 4'd4, 1'b0);
    push(0, 64'hC000_0000_0000_00C2, 4'd4, 1'b1);
    expb(64'hB100_0000_0000_0001, 4'd9, 1'b0, 1, 1);
    expb(64'hB100_0000_0000_00B1, 4'd9, 1'b0, 1, 3);
    expb(64'hB100_0000_0000_00B2, 4'd9, 1'b1, 1, 5);
    expb(64'hC000_0000_0000_0001, 4'd4, 1'b0, 0, 7);
    expb(64'hC000_0000_0000_00C1, 4'd4, 1'b0, 0, 9);
    expb(64'hC000_0000_0000_00C2, 4'd4, 1'b1, 0, 11);
    run("stall", 80);
    check_log("stall");
    toggle_rdy = 1'b0;

    // SETUP_HW_INST packet ending on TID, then three EXEC_TASK commands to
    // dest 3; the repeated argument lets the copy-in bit be dropped.
    do_reset();
    push(0, 64'h0000_0000_0000_0001, 4'd7, 1'b0);
    push(0, 64'h0000_0000_0000_0077, 4'd7, 1'b1);
    expb(64'h0000_0000_0000_0001, 4'd7, 1'b0, 0, -1);
    expb(64'h0000_0000_0000_0077, 4'd7, 1'b1, 0, -1);
    for (int k = 0; k < 3; k++) begin
      arg = (k == 2) ? 64'h0000_0000_0000_2000 : 64'h0000_0000_0000_1000;
      push(0, 64'h0000_0000_0000_0102, 4'd3, 1'b0);
      push(0, 64'h0000_0000_0000_0031, 4'd3, 1'b0);
      push(0, 64'h0000_0000_0000_0032, 4'd3, 1'b0);
      push(0, 64'h0000_0000_0000_0010, 4'd3, 1'b0);
      push(0, arg,                     4'd3, 1'b1);
      expb(64'h0000_0000_0000_0102, 4'd3, 1'b0, 0, -1);
      expb(64'h0000_0000_0000_0031, 4'd3, 1'b0, 0, -1);
      expb(64'h0000_0000_0000_0032, 4'd3, 1'b0, 0, -1);
      expb((k == 1 && OPT) ? 64'h0 : 64'h10, 4'd3, 1'b0, 0, -1);
      expb(arg, 4'd3, 1'b1, 0, -1);
    end
    run("copyopt", 200);
    check_log("copyopt");

    // Reset in the middle of a source-0 packet, then a fresh source-1 packet.
    do_reset();
    for (int j = 0; j < 5; j++)
      push(0, {8'hD0, 8'(j), 48'h0000_0000_0001}, 4'd2, j == 4);
    expb({8'hD0, 8'd0, 48'h0000_0000_0001}, 4'd2, 1'b0, 0, 1);
    expb({8'hD0, 8'd1, 48'h0000_0000_0001}, 4'd2, 1'b0, 0, 2);
    repeat (3) tick();
    rst = 1'b1;
    q0.delete(); q1.delete();
    drive();
    @(posedge clk);
    #1;
    chk_idle("rst_mid");
    check_log("rst_mid.pre");
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    push(1, 64'hE100_0000_0000_0001, 4'd6, 1'b0);
    push(1, 64'hE100_0000_0000_00E1, 4'd6, 1'b0);
    push(1, 64'hE100_0000_0000_00E2, 4'd6, 1'b1);
    expb(64'hE100_0000_0000_0001, 4'd6, 1'b0, 1, 1);
    expb(64'hE100_0000_0000_00E1, 4'd6, 1'b0, 1, 2);
    expb(64'hE100_0000_0000_00E2, 4'd6, 1'b1, 1, 3);
    run("after_rst", 40);
    check_log("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
